acc_cpu_sequencer: RTL
======================

Name: acc_cpu_sequencer

Overview:
Program sequencer for the 8-bit accumulator datapath (ALU, instruction register, accumulator).
- Fetches 13-bit instructions from an external instruction memory over a req/ack handshake.
- Holds the program counter and drives the datapath strobes: ir_load (IR load), acc_load (accumulator load) and fetch (fetch indicator).
- Latches the ALU flags and resolves jumps, conditional branches and halt.
- Replaces the free-running 3-state control loop with a start/stop, stall-tolerant controller.

Parameters:
PC_WIDTH, 8, program counter and instruction address width; wraps modulo 2^PC_WIDTH.
FETCH_TIMEOUT, 16, maximum cycles FETCH waits for imem_ack before it aborts; must be at least 1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  level-sampled; launches execution from IDLE or HALT.
imem_req  output  1  instruction fetch request.
imem_addr  output  PC_WIDTH  fetch address; equals pc.
imem_ack  input  1  memory has valid imem_data this cycle.
imem_data  input  13  [12:11] class, [10:8] opcode, [7:0] literal.
ir_data  output  11  {opcode, literal} of the current instruction, to the IR input.
ir_load  output  1  IR load strobe (the datapath d).
acc_load  output  1  accumulator load strobe (the datapath e).
fetch  output  1  high while in FETCH (the datapath f; drives the LED).
zero_in, carry_in, neg_in, ovf_in  input  1 each  combinational ALU flags.
flags  output  4  latched {ovf, neg, carry, zero}.
pc  output  PC_WIDTH  current program counter.
busy  output  1  high in FETCH, DECODE or EXEC.
halted  output  1  high in HALT.
fault  output  1  sticky; set on fetch timeout.

Behaviour:
Reset (asynchronous, rst_n=0):
- State goes to IDLE.
- pc=0, flags=0, fault=0, instruction latch=0.
- All strobes, imem_req, busy and halted are 0.
- Reset asserted mid-operation aborts any fetch immediately; imem_req drops in the same instant.

Instruction classes ([12:11]):
- 00 ALU: opcode selects the ALU operation, literal is operand a.
- 01 JMP: pc <= literal.
- 10 BR: flag chosen by opcode[1:0] (0=zero, 1=carry, 2=neg, 3=ovf); opcode[2]=1 inverts the test. Taken -> pc <= literal, else pc <= pc+1.
- 11 HLT.

States:
- IDLE: all outputs low. start=1 -> FETCH.
- FETCH:
  - fetch=1, imem_req=1, imem_addr=pc.
  - On imem_ack=1, imem_data is captured into the instruction latch and the state goes to DECODE. Ack in the first FETCH cycle is legal.
  - A wait counter clears on FETCH entry. After FETCH_TIMEOUT cycles without ack: fault<=1, go to HALT.
- DECODE: ir_load=1 for exactly one cycle; ir_data is valid from this cycle onward.
  - ALU -> EXEC.
  - JMP/BR: update pc as above -> FETCH.
  - HLT -> HALT; pc is unchanged and points at the HLT.
- EXEC:
  - acc_load=1 for exactly one cycle.
  - At the closing edge: flags <= {ovf_in, neg_in, carry_in, zero_in}, pc <= pc+1 -> FETCH.
- HALT: halted=1; holds until start=1, then pc<=0, flags<=0, fault<=0 -> FETCH.

Timing and boundary rules:
- Minimum latency: ALU instruction 3 cycles; JMP/BR 2 cycles (ack in the first FETCH cycle).
- imem_ack outside FETCH is ignored. start outside IDLE/HALT is ignored.
- pc wraps from 2^PC_WIDTH-1 to 0 on increment; no fault is raised.
- Flags change only in EXEC. BR tests the flags latched by the most recent EXEC.
- ir_load and acc_load are never high in the same cycle. Each fires at most once per instruction.
- All outputs are registered or decoded from the state register only; there are no combinational paths from inputs to strobes.

Test Plan:
Plain ALU sequence:
- Stimulus: memory with 0 ack latency; program 00_100_0x05 (a pass -> acc=5), 00_000_0x03, 11.
- Response: acc_load pulses at cycles 3 and 6; imem_addr sequence 0,1,2; halted=1 with pc=2.
- Response: flags captured at the second EXEC reflect ALU input a=0x03, b=0x05.

Branch taken / not taken:
- Stimulus: flags.zero=1, then 10_000_0x40; then flags.zero=0 with 10_100_0x40.
- Response: pc=0x40 in both cases.
- Response: a not-taken case gives pc+1; no acc_load occurs for BR instructions.

Ack stall and timeout:
- Stimulus: ack delayed 5 cycles.
- Response: fetch/imem_req stay high for 6 cycles, then normal decode.
- Stimulus: ack withheld.
- Response: after 16 cycles halted=1, fault=1, busy=0.

PC wrap:
- Stimulus: JMP to 0xFF, then an ALU instruction at 0xFF.
- Response: next imem_addr=0x00, fault=0.

Reset mid-fetch:
- Stimulus: rst_n low during a FETCH wait.
- Response: imem_req=0, fetch=0, pc=0 immediately, without waiting for a clock edge.
- Response: with start held high after release, FETCH re-enters at the next edge with imem_addr=0.

Restart from HALT:
- Stimulus: start pulse while halted with fault=1.
- Response: pc=0, flags=0, fault=0, FETCH on the next cycle.

Source files
------------

// File: rtl/acc_cpu_sequencer.sv
// Program sequencer for the 8-bit accumulator datapath: fetches 13-bit instructions
// over a req/ack handshake, holds the pc and flags, and resolves jumps, branches and halt.
module acc_cpu_sequencer #(
  parameter int PC_WIDTH      = 8,
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [12:0]         imem_data,
  output logic [10:0]         ir_data,
  output logic                ir_load,
  output logic                acc_load,
  output logic                fetch,
  input  logic                zero_in,
  input  logic                carry_in,
  input  logic                neg_in,
  input  logic                ovf_in,
  output logic [3:0]          flags,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                halted,
  output logic                fault
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [1:0] C_ALU = 2'b00;
  localparam logic [1:0] C_JMP = 2'b01;
  localparam logic [1:0] C_BR  = 2'b10;

  localparam int                CNT_W    = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  logic [2:0]          state;
  logic [12:0]         instr;
  logic [CNT_W-1:0]    wait_cnt;
  logic [1:0]          instr_class;
  logic [2:0]          opcode;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] pc_next_seq;
  logic                br_taken;

  assign instr_class = instr[12:11];
  assign opcode      = instr[10:8];
  assign target      = PC_WIDTH'(instr[7:0]);
  assign pc_next_seq = pc + PC_WIDTH'(1);
  // flags is {ovf, neg, carry, zero}, so opcode[1:0] indexes the tested flag directly.
  assign br_taken    = flags[opcode[1:0]] ^ opcode[2];

  // Every output is a decode of registered state, so no input reaches a strobe combinationally.
  assign fetch     = (state == S_FETCH);
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign ir_load   = (state == S_DECODE);
  assign acc_load  = (state == S_EXEC);
  assign busy      = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
  assign halted    = (state == S_HALT);
  assign ir_data   = instr[10:0];

  // NOTE: all state updates use non-blocking assignment so every register sees
  // pre-edge values; the instruction latch is reset too so ir_data is defined from power-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= '0;
      flags    <= '0;
      fault    <= 1'b0;
      instr    <= '0;
      wait_cnt <= '0;
    end else begin
      // The wait counter idles at zero outside FETCH, which clears it on every entry.
      wait_cnt <= '0;
      case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr <= imem_data;
            state <= S_DECODE;
          end else if (wait_cnt == CNT_LAST) begin
            fault <= 1'b1;
            state <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          case (instr_class)
            C_ALU: state <= S_EXEC;
            C_JMP: begin
              pc    <= target;
              state <= S_FETCH;
            end
            C_BR: begin
              pc    <= br_taken ? target : pc_next_seq;
              state <= S_FETCH;
            end
            default: state <= S_HALT;
          endcase
        end
        S_EXEC: begin
          flags <= {ovf_in, neg_in, carry_in, zero_in};
          pc    <= pc_next_seq;
          state <= S_FETCH;
        end
        S_HALT: begin
          if (start) begin
            pc    <= '0;
            flags <= '0;
            fault <= 1'b0;
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
